ram_nr_nw_lvt: RTL
==================

// Module: ram_nr_nw_lvt
// PURPOSE
//  Parametrised multi-port RAM: NUM_R read ports, NUM_W write ports, one clock.
//  - Reads: replicated 1R1W banks, NUM_W x NUM_R in total.
//  - Writes: a Live Value Table (LVT) records which write port last wrote each address.
//  - Generalises the fixed 16R1W replicated-read RAM to N writers.
//  - Adds a registered read stage, deterministic write collisions and post-reset memory clear.
// PARAMETERS
//  ADDR_W  11  address width; depth = 2**ADDR_W (2048)
//  DATA_W  32  data word width
//  NUM_R   16  read ports, 1..16
//  NUM_W   2   write ports, 1..4
//  LVT_W   $clog2(NUM_W), min 1   width of one LVT entry (derived, not overridable)
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  w_enb      in   NUM_W          per-port write enable
//  w_addr     in   NUM_W*ADDR_W   write addresses; port k at [k*ADDR_W +: ADDR_W]
//  w_din      in   NUM_W*DATA_W   write data; port k at [k*DATA_W +: DATA_W]
//  r_addr     in   NUM_R*ADDR_W   read addresses, packed the same way
//  r_dout     out  NUM_R*DATA_W   read data, registered
//  init_done  out  1              1 = memory clear finished; writes are accepted
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): r_dout=0, init_done=0, init counter=0, FSM=INIT.
//    Bank and LVT contents are not touched by reset itself.
//  - FSM INIT: each cycle writes 0 to address cnt in every bank and sets LVT[cnt]=0.
//    cnt increments by 1. When cnt == 2**ADDR_W-1 the FSM moves to RUN and init_done=1
//    on the next cycle. INIT lasts exactly 2**ADDR_W cycles.
//  - In INIT, w_enb is ignored and r_dout holds 0.
//  - rst asserted mid-INIT restarts the clear from address 0.
//  - FSM RUN: for each k with w_enb[k]=1, data is written to address w_addr[k] in all NUM_R
//    banks of column k, and LVT[w_addr[k]] <= k. Stays in RUN until rst.
//  - Write collision (two or more enabled ports on the same address): the highest port
//    index wins in both the LVT and the read result. The losers' bank writes are harmless.
//  - Read latency is 1 cycle: r_dout[j] at edge t+1 = bank[LVT[r_addr[j]]][j][r_addr[j]],
//    with both the LVT and the banks sampled at edge t.
//  - Read-during-write to the same address in the same cycle returns the OLD value
//    (read-first), unless WR_BYPASS_EN is defined.
//  - r_dout for a port never written since init = 0.
//  - Addresses wrap naturally within ADDR_W bits; there are no out-of-range addresses.
// CONFIGURATION
//  WR_BYPASS_EN defined:
//    - A read whose address matches an enabled same-cycle write returns the NEW data.
//    - Among several matching writers, the highest matching port index supplies the data.
//    - The forward path is combinational from w_din into the r_dout register.
//  WR_BYPASS_EN undefined: read-first behaviour, no forward logic.
// STRUCTURE
//  - Package ram_mp_pkg:
//    - Constants MAX_NUM_R=16, MAX_NUM_W=4.
//    - Function lvt_w(num_w) returning the LVT entry width.
//    - Typedef fsm_t {INIT, RUN}.
//  - Sub-module ram_1r1w: ADDR_W x DATA_W, synchronous write, registered read, no reset.
//    Instantiated NUM_W*NUM_R times in a generate grid.
//  - The LVT (flop array, NUM_W write / NUM_R read), the init FSM/counter and the
//    per-read-port output mux live in this top module.
// TESTING (defaults unless noted; ADDR_W=4 for fast-init runs)
//  1. Reset, then hold: init_done=0 for exactly 2048 cycles, then 1. Every r_dout reads 0
//     at addresses 0, 1023, 2047.
//  2. Write port0 @0x010=0xDEADBEEF; next cycle read it on all 16 ports -> all return
//     0xDEADBEEF one cycle after the address is applied.
//  3. Same cycle: port0 @0x020=0x11111111 and port1 @0x020=0x22222222; read 0x020 on
//     ports 0..15 -> 0x22222222 (collision rule).
//  4. Port1 @0x030=0xAAAA0000, then port0 @0x030=0x0000BBBB; read -> 0x0000BBBB
//     (LVT tracks the last writer).
//  5. Mem[0x040]=0x5 already; write 0x6 @0x040 while reading 0x040 in the same cycle ->
//     0x5 without WR_BYPASS_EN, 0x6 with it; the read on the next cycle -> 0x6.
//  6. ADDR_W=4: rst pulsed at init cycle 7 -> init_done rises exactly 16 cycles after the
//     pulse. A port0 write issued during INIT is dropped (read returns 0 afterwards).

Source files
------------

// File: rtl/ram_mp_pkg.sv
// Shared types and constants for the multi-port LVT RAM.
// Optional feature macro used by the top: WR_BYPASS_EN.
package ram_mp_pkg;

  localparam int MAX_NUM_R = 16;
  localparam int MAX_NUM_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // LVT entry width: enough bits to name a write port, never narrower than 1.
  function automatic int lvt_w(input int num_w);
    if (num_w <= 1) begin
      return 1;
    end else begin
      return $clog2(num_w);
    end
  endfunction

endpackage

// File: rtl/ram_1r1w.sv
// Simple dual-port bank: synchronous write, registered read, no reset.
// A read of the address being written returns the old contents.
module ram_1r1w #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // storage write and registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ram_nr_nw_lvt.sv
// NUM_R-read / NUM_W-write RAM built from replicated 1R1W banks and a Live Value Table.
// Define WR_BYPASS_EN to forward same-cycle write data to matching reads.
module ram_nr_nw_lvt
  import ram_mp_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int NUM_R  = 16,
  parameter int NUM_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_W-1:0]        w_enb,
  input  logic [NUM_W*ADDR_W-1:0] w_addr,
  input  logic [NUM_W*DATA_W-1:0] w_din,
  input  logic [NUM_R*ADDR_W-1:0] r_addr,
  output logic [NUM_R*DATA_W-1:0] r_dout,
  output logic                    init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LVT_W = lvt_w(NUM_W);

  fsm_t              state_r, state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              init_done_r;
  logic              out_en_r;

  logic [LVT_W-1:0]  lvt_r     [DEPTH];
  logic [LVT_W-1:0]  lvt_sel_r [NUM_R];

  logic [NUM_W-1:0]  bank_we_s;
  logic [ADDR_W-1:0] bank_wa_s [NUM_W];
  logic [DATA_W-1:0] bank_wd_s [NUM_W];
  logic [DATA_W-1:0] bank_q_s  [NUM_W][NUM_R];

  logic              byp_hit_r  [NUM_R];
  logic [DATA_W-1:0] byp_data_r [NUM_R];

  // init/run next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (cnt_r == {ADDR_W{1'b1}}) begin
          state_s = RUN;
        end else begin
          state_s = INIT;
        end
      end
      RUN:     state_s = RUN;
      default: state_s = INIT;
    endcase
  end

  // FSM state, clear counter and output-enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      cnt_r       <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
      out_en_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= (state_r == INIT) ? cnt_r + ADDR_W'(1) : cnt_r;
      init_done_r <= (state_s == RUN);
      out_en_r    <= (state_r == RUN);
    end
  end

  // bank write-port steering: clear pattern during INIT, user ports during RUN
  always_comb begin
    for (int k = 0; k < NUM_W; k++) begin
      bank_we_s[k] = 1'b0;
      bank_wa_s[k] = {ADDR_W{1'b0}};
      bank_wd_s[k] = {DATA_W{1'b0}};
      if (rst) begin
        bank_we_s[k] = 1'b0;
      end else if (state_r == INIT) begin
        bank_we_s[k] = 1'b1;
        bank_wa_s[k] = cnt_r;
      end else begin
        bank_we_s[k] = w_enb[k];
        bank_wa_s[k] = w_addr[k*ADDR_W +: ADDR_W];
        bank_wd_s[k] = w_din[k*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar k = 0; k < NUM_W; k++) begin : g_col
    for (genvar j = 0; j < NUM_R; j++) begin : g_row
      ram_1r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we_s[k]),
        .waddr (bank_wa_s[k]),
        .wdata (bank_wd_s[k]),
        .raddr (r_addr[j*ADDR_W +: ADDR_W]),
        .rdata (bank_q_s[k][j])
      );
    end
  end

  // LVT update (ascending port order, so the highest colliding port wins) and read sampling
  always_ff @(posedge clk) begin
    if (!rst && state_r == INIT) begin
      lvt_r[cnt_r] <= {LVT_W{1'b0}};
    end else if (!rst && state_r == RUN) begin
      for (int k = 0; k < NUM_W; k++) begin
        if (w_enb[k]) begin
          lvt_r[w_addr[k*ADDR_W +: ADDR_W]] <= LVT_W'(k);
        end
      end
    end
    for (int j = 0; j < NUM_R; j++) begin
      lvt_sel_r[j] <= lvt_r[r_addr[j*ADDR_W +: ADDR_W]];
    end
  end

`ifdef WR_BYPASS_EN
  logic              byp_hit_s  [NUM_R];
  logic [DATA_W-1:0] byp_data_s [NUM_R];

  // same-cycle write match per read port; later (higher) ports override earlier ones
  always_comb begin
    for (int j = 0; j < NUM_R; j++) begin
      byp_hit_s[j]  = 1'b0;
      byp_data_s[j] = {DATA_W{1'b0}};
      for (int k = 0; k < NUM_W; k++) begin
        if (!rst && state_r == RUN && w_enb[k] &&
            w_addr[k*ADDR_W +: ADDR_W] == r_addr[j*ADDR_W +: ADDR_W]) begin
          byp_hit_s[j]  = 1'b1;
          byp_data_s[j] = w_din[k*DATA_W +: DATA_W];
        end else begin
          byp_hit_s[j]  = byp_hit_s[j];
          byp_data_s[j] = byp_data_s[j];
        end
      end
    end
  end

  // forwarded data register
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_R; j++) begin
      byp_hit_r[j]  <= byp_hit_s[j];
      byp_data_r[j] <= byp_data_s[j];
    end
  end
`else
  // read-first build: forwarding never selected
  always_comb begin
    for (int j = 0; j < NUM_R; j++) begin
      byp_hit_r[j]  = 1'b0;
      byp_data_r[j] = {DATA_W{1'b0}};
    end
  end
`endif

  // per-read-port selection of the live bank, forced to zero until the memory is cleared
  always_comb begin
    logic [DATA_W-1:0] word_v;
    r_dout = {(NUM_R*DATA_W){1'b0}};
    for (int j = 0; j < NUM_R; j++) begin
      word_v = bank_q_s[0][j];
      for (int k = 0; k < NUM_W; k++) begin
        if (lvt_sel_r[j] == LVT_W'(k)) begin
          word_v = bank_q_s[k][j];
        end else begin
          word_v = word_v;
        end
      end
      if (byp_hit_r[j]) begin
        word_v = byp_data_r[j];
      end else begin
        word_v = word_v;
      end
      if (out_en_r) begin
        r_dout[j*DATA_W +: DATA_W] = word_v;
      end else begin
        r_dout[j*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  assign init_done = init_done_r;

endmodule
